hack_cpu_ctrl: RTL
==================

# hack_cpu_ctrl

Multi-cycle control and register core for the Hack CPU. Fetches 16-bit instructions, holds the A/D/PC registers and decodes each C-instruction into the six ALU control bits plus an A/M select. It consumes the ALU's result and zr/ng flags to write back destinations and resolve jumps. It sits between instruction ROM, data RAM (both req/ack) and the external combinational ALU.

## Interface
Parameters:
- none (Hack widths fixed: 16-bit data, 15-bit addresses)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- instr_req  out  1  instruction fetch request
- instr_addr  out  15  fetch address (= PC)
- instr_ack  in  1  fetch complete; instr valid this cycle
- instr  in  16  instruction word
- mem_req  out  1  data memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  15  = A[14:0]
- mem_wdata  out  16  write data
- mem_ack  in  1  data transaction complete
- mem_rdata  in  16  read data, valid with mem_ack on a read
- alu_x  out  16  = D
- alu_y  out  16  = A when a-bit = 0, latched M when a-bit = 1
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  = IR[11:6]
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU flags
- pc  out  15  program counter (debug/observation)

## Operation
- States: IDLE, FETCH, DECODE, MREAD, EXEC, MWRITE.
- IDLE: entered on reset; moves to FETCH unconditionally on the next edge.
- FETCH: instr_req = 1 and instr_addr = PC. On an edge with instr_ack = 1, IR <= instr and the FSM moves to DECODE. Otherwise it holds.
- DECODE, A-instruction (IR[15] = 0): A <= {1'b0, IR[14:0]}, PC <= PC+1, then FETCH.
- DECODE, C-instruction: go to MREAD if IR[12] = 1, else EXEC. IR[14:13] are ignored.
- MREAD: mem_req = 1, mem_we = 0, mem_addr = A. On mem_ack, M latch <= mem_rdata and the FSM moves to EXEC.
- EXEC: ALU controls and alu_y are driven from IR. At the edge:
  - dest IR[5] (A): A <= alu_out
  - dest IR[4] (D): D <= alu_out
  - wdata <= alu_out; A_old <= A
  - zr/ng sampled
  - go to MWRITE if IR[3] (M), else resolve PC and go to FETCH
- MWRITE: mem_req = 1, mem_we = 1, mem_addr = A_old[14:0], mem_wdata = wdata. On mem_ack, resolve PC and go to FETCH.
- PC resolve: jump = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~zr & ~ng).
  - Jump taken: PC <= A_old[14:0], the A value before this instruction's write.
  - Otherwise: PC <= PC+1.
- PC arithmetic is 15-bit and wraps 0x7FFF -> 0x0000.
- Outside EXEC, ALU controls are 0 and alu_y = A.

## Timing
- Reset values: state IDLE; A, D, PC, IR, M latch and wdata all 0; instr_req, mem_req and mem_we 0; ALU controls 0.
- All request outputs are decoded from registered state. A request is held until its ack is sampled high on a clock edge. Acks arriving outside the matching state are ignored.
- Minimum latency with zero-wait ack:
  - A-instruction: 2 cycles (FETCH, DECODE)
  - C-instruction without M: 3 cycles
  - each M read or M write: +1 cycle
  - C-instruction reading and writing M: 5 cycles
- Dest AM with a jump: the jump target and the write address both use A_old.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous) and the in-flight request is dropped. After rst_n rises, one IDLE cycle precedes a refetch from address 0.

## Structure
- Package hack_pkg holds:
  - the state enum
  - IR field positions (A_BIT = 12, ALU_CTL = 11:6, DEST = 5:3, JMP = 2:0)
  - dest/jump bit constants
  - ADDR_W = 15, DATA_W = 16
- Sub-module hack_jump_eval (combinational): jump bits, zr and ng in; taken out.

## Test plan
- Reset, then zero-wait fetch of 0x0005 at PC 0: A = 0x0005 and PC = 1 after 2 cycles; instr_req high in FETCH only.
- A = 5, D = 0, then 0xEC10 (D=A): alu_zx..no = 110000 during EXEC; D = 5, PC increments, no mem_req.
- A = 0x0010, RAM[0x10] = 7, then 0xFC10 (D=M) with mem_ack delayed 3 cycles: mem_req held 3 cycles, then D = 7.
- A = 0x0020, D = 3, then 0xE7C8 (M=D+1): one write with mem_addr = 0x0020 and wdata = 4, PC+1.
- A = 0x0100, D = 0, then 0xE302 (D;JEQ) resolves to PC = 0x0100. Same with D = 1 gives PC+1. 0xE301 (JGT) with D = 0xFFFF is not taken.
- rst_n pulsed low during MWRITE with ack pending: mem_req drops asynchronously; after release, IDLE then FETCH at PC 0.

Source files
------------

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and instruction field positions for the Hack control core
//
// Purpose: FSM state encoding, Hack widths and the bit positions of the
// C-instruction fields. Dest/jump bit constants index into the 3-bit field
// slices (dest = IR[DEST_HI:DEST_LO], jmp = IR[JMP_HI:JMP_LO]).
package hack_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  localparam int CI_BIT     = 15;  // 1 = C-instruction
  localparam int A_BIT      = 12;  // 1 = ALU y operand comes from M
  localparam int ALU_CTL_HI = 11;
  localparam int ALU_CTL_LO = 6;
  localparam int DEST_HI    = 5;
  localparam int DEST_LO    = 3;
  localparam int JMP_HI     = 2;
  localparam int JMP_LO     = 0;

  // Bit positions inside the 3-bit dest field
  localparam int DST_A = 2;
  localparam int DST_D = 1;
  localparam int DST_M = 0;

  // Bit positions inside the 3-bit jump field
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MREAD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MWRITE = 3'd5
  } state_t;

endpackage

// File: rtl/hack_jump_eval.sv
// rtl/hack_jump_eval.sv - combinational jump condition evaluator
//
// Ports:
//   jmp   in  3  jump field (LT, EQ, GT)
//   zr    in  1  result == 0
//   ng    in  1  result < 0
//   taken out 1  jump condition satisfied
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  assign taken = (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - multi-cycle Hack CPU control and register core
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   instr_req/addr/ack, instr        instruction ROM fetch handshake
//   mem_req/we/addr/wdata/ack/rdata  data RAM handshake
//   alu_x, alu_y, alu_zx..alu_no     operands and controls to the external ALU
//   alu_out, alu_zr, alu_ng          ALU result and flags
//   pc                               program counter (observation)
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [DATA_W-1:0] instr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] a_reg, d_reg, ir, m_latch, wdata;
  logic [ADDR_W-1:0] pc_reg, a_old;
  logic              zr_q, ng_q;

  logic [2:0]        dest, jmp;
  logic [5:0]        alu_ctl;
  logic              flag_zr, flag_ng, taken;
  logic [ADDR_W-1:0] jmp_target, pc_inc, pc_resolved;

  assign dest = ir[DEST_HI:DEST_LO];
  assign jmp  = ir[JMP_HI:JMP_LO];

  // In EXEC the jump resolves against the live ALU flags and the current A;
  // in MWRITE it uses the copies captured at the end of EXEC, since A may
  // already hold the new result.
  always_comb begin
    if (state == ST_EXEC) begin
      flag_zr    = alu_zr;
      flag_ng    = alu_ng;
      jmp_target = a_reg[ADDR_W-1:0];
    end else begin
      flag_zr    = zr_q;
      flag_ng    = ng_q;
      jmp_target = a_old;
    end
  end

  hack_jump_eval u_jump_eval (
    .jmp   (jmp),
    .zr    (flag_zr),
    .ng    (flag_ng),
    .taken (taken)
  );

  assign pc_inc      = pc_reg + 15'd1;  // wraps 0x7FFF -> 0x0000
  assign pc_resolved = taken ? jmp_target : pc_inc;

  always_comb begin
    state_nx  = state;
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = a_reg[ADDR_W-1:0];
    alu_ctl   = 6'b0;
    alu_y     = a_reg;
    unique case (state)
      ST_IDLE:   state_nx = ST_FETCH;
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (!ir[CI_BIT])     state_nx = ST_FETCH;
        else if (ir[A_BIT])  state_nx = ST_MREAD;
        else                 state_nx = ST_EXEC;
      end
      ST_MREAD: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        alu_ctl  = ir[ALU_CTL_HI:ALU_CTL_LO];
        alu_y    = ir[A_BIT] ? m_latch : a_reg;
        state_nx = dest[DST_M] ? ST_MWRITE : ST_FETCH;
      end
      ST_MWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = a_old;
        if (mem_ack) state_nx = ST_FETCH;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      d_reg   <= '0;
      pc_reg  <= '0;
      ir      <= '0;
      m_latch <= '0;
      wdata   <= '0;
      a_old   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_FETCH:  if (instr_ack) ir <= instr;
        ST_DECODE: begin
          if (!ir[CI_BIT]) begin
            a_reg  <= {1'b0, ir[ADDR_W-1:0]};
            pc_reg <= pc_inc;
          end
        end
        ST_MREAD:  if (mem_ack) m_latch <= mem_rdata;
        ST_EXEC: begin
          if (dest[DST_A]) a_reg <= alu_out;
          if (dest[DST_D]) d_reg <= alu_out;
          wdata <= alu_out;
          a_old <= a_reg[ADDR_W-1:0];
          zr_q  <= alu_zr;
          ng_q  <= alu_ng;
          if (!dest[DST_M]) pc_reg <= pc_resolved;
        end
        ST_MWRITE: if (mem_ack) pc_reg <= pc_resolved;
        default: ;
      endcase
    end
  end

  assign instr_addr = pc_reg;
  assign pc         = pc_reg;
  assign mem_wdata  = wdata;
  assign alu_x      = d_reg;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctl;

endmodule
